cwt_conv_mac_ctrl: RTL and testbench

- Sequences one shared signed fixed-point multiplier to compute one CWT output point: sum over k of coef[k]*sample[base+k].
- Reads the wavelet-coefficient ROM and the sample RAM, drives the external combinational multiplier (BITS-wide, TRANC fractional bits, truncating), and accumulates the products.
- Returns one saturated result per start over a valid/ready handshake.
- Sits between the scale/shift scheduler (issues start) and the scalogram writer (consumes result).

---
 rtl/cwt_conv_mac_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cwt_conv_mac_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cwt_conv_mac_ctrl.sv
// cwt_conv_mac_ctrl: sequences one shared fixed-point multiplier to compute a
// single CWT output point, sum_k coef[k] * sample[base + k], and returns the
// saturated sum over a valid/ready handshake.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   start             request a convolution; accepted only when idle
//   sample_base, len  first sample address and tap count, captured at accept
//   busy              high from accept until the result handshake completes
//   coef_rd_en/addr   coefficient ROM read port (data returns 1 cycle later)
//   samp_rd_en/addr   sample RAM read port (data returns 1 cycle later)
//   coef_data/samp_data  memory read data
//   mul_in1/mul_in2   registered multiplier operands (sample, coefficient)
//   mul_out           combinational product from the shared multiplier
//   result, result_sat, result_valid, result_ready  saturated result handshake
module cwt_conv_mac_ctrl #(
    parameter int unsigned BITS      = 16,
    parameter int unsigned TRANC     = 8,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LEN_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] sample_base,
    input  logic [LEN_BITS-1:0]  len,
    output logic                 busy,
    output logic                 coef_rd_en,
    output logic [LEN_BITS-1:0]  coef_addr,
    input  logic [BITS-1:0]      coef_data,
    output logic                 samp_rd_en,
    output logic [ADDR_BITS-1:0] samp_addr,
    input  logic [BITS-1:0]      samp_data,
    output logic [BITS-1:0]      mul_in1,
    output logic [BITS-1:0]      mul_in2,
    input  logic [BITS-1:0]      mul_out,
    output logic [BITS-1:0]      result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 result_sat
);

    localparam int unsigned ACC_W = BITS + LEN_BITS;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (BITS - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // The multiplier already rescales; the fraction width only has to be sane.
    if (TRANC >= BITS) begin : g_bad_tranc
        $error("TRANC must be smaller than BITS");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [ADDR_BITS-1:0]      base_q, base_nxt;
    logic [LEN_BITS-1:0]       len_q, len_nxt;
    logic [LEN_BITS-1:0]       tap, tap_nxt;
    logic                      busy_nxt;
    logic                      rd_en_nxt;
    logic [LEN_BITS-1:0]       coef_addr_nxt;
    logic [ADDR_BITS-1:0]      samp_addr_nxt;
    logic [BITS-1:0]           result_nxt;
    logic                      result_valid_nxt;
    logic                      result_sat_nxt;
    logic                      acc_clr;
    logic                      v1, v2;
    logic signed [ACC_W-1:0]   acc;
    logic                      sat_hi, sat_lo;

    assign sat_hi = (acc > SAT_MAX);
    assign sat_lo = (acc < SAT_MIN);

    // State and registered control outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            tap          <= '0;
            busy         <= 1'b0;
            coef_rd_en   <= 1'b0;
            samp_rd_en   <= 1'b0;
            coef_addr    <= '0;
            samp_addr    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            result_sat   <= 1'b0;
        end else begin
            state        <= state_nxt;
            base_q       <= base_nxt;
            len_q        <= len_nxt;
            tap          <= tap_nxt;
            busy         <= busy_nxt;
            coef_rd_en   <= rd_en_nxt;
            samp_rd_en   <= rd_en_nxt;
            coef_addr    <= coef_addr_nxt;
            samp_addr    <= samp_addr_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            result_sat   <= result_sat_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt        = state;
        base_nxt         = base_q;
        len_nxt          = len_q;
        tap_nxt          = tap;
        busy_nxt         = busy;
        rd_en_nxt        = 1'b0;
        coef_addr_nxt    = '0;
        samp_addr_nxt    = '0;
        result_nxt       = result;
        result_valid_nxt = result_valid;
        result_sat_nxt   = result_sat;
        acc_clr          = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    busy_nxt = 1'b1;
                    base_nxt = sample_base;
                    len_nxt  = len;
                    acc_clr  = 1'b1;
                    if (len == '0) begin
                        // Empty pipeline: DRAIN finishes on the very next edge.
                        state_nxt = S_DRAIN;
                    end else begin
                        state_nxt     = S_RUN;
                        rd_en_nxt     = 1'b1;
                        samp_addr_nxt = sample_base;
                        tap_nxt       = LEN_BITS'(1);
                    end
                end
            end
            S_RUN: begin
                if (tap == len_q) begin
                    state_nxt = S_DRAIN;
                end else begin
                    rd_en_nxt     = 1'b1;
                    coef_addr_nxt = tap;
                    samp_addr_nxt = base_q + ADDR_BITS'(tap);
                    tap_nxt       = tap + LEN_BITS'(1);
                end
            end
            S_DRAIN: begin
                if (!v1 && !v2) begin
                    state_nxt        = S_DONE;
                    result_valid_nxt = 1'b1;
                    result_sat_nxt   = sat_hi || sat_lo;
                    result_nxt       = sat_hi ? BITS'(SAT_MAX) :
                                       sat_lo ? BITS'(SAT_MIN) : BITS'(acc);
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    state_nxt        = S_IDLE;
                    result_valid_nxt = 1'b0;
                    busy_nxt         = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read -> operand -> accumulate pipeline; idle operands are zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            mul_in1 <= '0;
            mul_in2 <= '0;
            acc     <= '0;
        end else begin
            v1      <= coef_rd_en;
            v2      <= v1;
            mul_in1 <= v1 ? samp_data : '0;
            mul_in2 <= v1 ? coef_data : '0;
            if (acc_clr) begin
                acc <= '0;
            end else if (v2) begin
                acc <= acc + {{LEN_BITS{mul_out[BITS-1]}}, mul_out};
            end
        end
    end

endmodule

// File: tb/tb_cwt_conv_mac_ctrl.sv
// Bench for cwt_conv_mac_ctrl: memory and multiplier models, a reference
// convolution computed at accept, and a negedge monitor checking busy, read
// addresses/timing, result values, latency and stability under backpressure.
module tb_cwt_conv_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  sample_base;
    logic [7:0]  len;
    logic        busy;
    logic        coef_rd_en;
    logic [7:0]  coef_addr;
    logic [15:0] coef_data = '0;
    logic        samp_rd_en;
    logic [9:0]  samp_addr;
    logic [15:0] samp_data = '0;
    logic [15:0] mul_in1;
    logic [15:0] mul_in2;
    logic [15:0] mul_out;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        result_sat;

    always #5 clk = ~clk;

    cwt_conv_mac_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .sample_base(sample_base), .len(len),
        .busy(busy), .coef_rd_en(coef_rd_en), .coef_addr(coef_addr), .coef_data(coef_data),
        .samp_rd_en(samp_rd_en), .samp_addr(samp_addr), .samp_data(samp_data),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out),
        .result(result), .result_valid(result_valid), .result_ready(result_ready),
        .result_sat(result_sat)
    );

    logic [15:0] coef_rom [256];
    logic [15:0] samp_ram [1024];

    // Q8.8 truncating multiplier.
    function automatic logic [15:0] mul_fn(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        return p[23:8];
    endfunction

    assign mul_out = mul_fn(mul_in1, mul_in2);

    always @(posedge clk) begin
        if (coef_rd_en) coef_data <= coef_rom[coef_addr];
        if (samp_rd_en) samp_data <= samp_ram[samp_addr];
    end

    typedef struct {
        logic [15:0] res;
        logic        sat;
        int          t_valid;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] ca;
        logic [9:0] sa;
    } addr_t;

    exp_t  exp_q [$];
    addr_t addr_q [$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    model_busy = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: saturated sum of truncated products.
    task automatic ref_conv(input int base, input int n, output logic [15:0] res, output logic sat);
        longint sum = 0;
        for (int k = 0; k < n; k++) begin
            logic [15:0] p;
            p = mul_fn(samp_ram[(base + k) % 1024], coef_rom[k]);
            sum += longint'($signed(p));
        end
        if (sum > 32767) begin
            res = 16'h7FFF; sat = 1'b1;
        end else if (sum < -32768) begin
            res = 16'h8000; sat = 1'b1;
        end else begin
            res = 16'(sum); sat = 1'b0;
        end
    endtask

    // Transaction model: accept, expected reads and result, handshake.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            model_busy = 1'b0;
            exp_q.delete();
            addr_q.delete();
        end else if (!model_busy) begin
            if (start) begin
                exp_t e;
                int   b;
                int   n;
                b = int'(sample_base);
                n = int'(len);
                ref_conv(b, n, e.res, e.sat);
                e.t_valid = (n == 0) ? cyc + 1 : cyc + n + 3;
                exp_q.push_back(e);
                for (int k = 0; k < n; k++)
                    addr_q.push_back('{cyc + k, 8'(k), 10'((b + k) % 1024)});
                model_busy = 1'b1;
            end
        end else if (result_valid && result_ready) begin
            model_busy = 1'b0;
        end
    end

    // Monitor.
    logic        prev_valid = 1'b0;
    logic [15:0] held_res;
    logic        held_sat;

    always @(negedge clk) begin
        chk("busy", busy, model_busy);
        if (coef_rd_en || samp_rd_en) begin
            if (addr_q.size() == 0) begin
                fail_now("unexpected_read");
            end else begin
                addr_t a;
                a = addr_q.pop_front();
                chk("rd_en_pair", {coef_rd_en, samp_rd_en}, 2'b11);
                chk("read_cycle", cyc, a.cyc);
                chk("coef_addr", coef_addr, a.ca);
                chk("samp_addr", samp_addr, a.sa);
            end
        end
        if (result_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("result_sat", result_sat, e.sat);
                chk("latency", cyc, e.t_valid);
            end
            held_res = result;
            held_sat = result_sat;
        end else if (result_valid && prev_valid) begin
            chk("result_stable", {result_sat, result}, {held_sat, held_res});
        end
        prev_valid = result_valid;
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, {coef_rd_en, samp_rd_en}, 0);
        chk({tag, "_addr"}, {coef_addr, samp_addr}, 0);
        chk({tag, "_mul_in"}, {mul_in1, mul_in2}, 0);
        chk({tag, "_result"}, {result_valid, result_sat, result}, 0);
    endtask

    // One convolution; stall = cycles result_ready stays low after valid.
    task automatic run(input int base, input int n, input bit hold_start, input int stall);
        int i;
        @(negedge clk);
        sample_base = 10'(base);
        len         = 8'(n);
        start       = 1'b1;
        if (stall > 0) result_ready = 1'b0;
        i = 0;
        while (!model_busy && i < 50) begin @(negedge clk); i++; end
        if (!model_busy) begin fail_now("accept_timeout"); start = 1'b0; return; end
        if (!hold_start) start = 1'b0;
        i = 0;
        while (!result_valid && i < 400) begin @(negedge clk); i++; end
        if (!result_valid) fail_now("valid_timeout");
        repeat (stall) @(negedge clk);
        result_ready = 1'b1;
        i = 0;
        while (model_busy && i < 50) begin @(negedge clk); i++; end
        if (model_busy) fail_now("handshake_timeout");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) samp_ram[i] = 16'($urandom);
        for (int i = 0; i < 256; i++) coef_rom[i] = 16'($urandom);
        rst = 1'b0; start = 1'b0; sample_base = '0; len = '0; result_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        // Single tap 1.0 * 2.0.
        samp_ram[10'h010] = 16'h0100; coef_rom[0] = 16'h0200;
        run(16'h010, 1, 1'b0, 0);

        // Four taps cancelling to zero, then all coefs 2.0.
        samp_ram[10'h100] = 16'h0100; samp_ram[10'h101] = 16'hFF00;
        samp_ram[10'h102] = 16'h0080; samp_ram[10'h103] = 16'h0200;
        coef_rom[0] = 16'h0100; coef_rom[1] = 16'h0100;
        coef_rom[2] = 16'hFF00; coef_rom[3] = 16'h0040;
        run(16'h100, 4, 1'b0, 0);
        for (int k = 0; k < 4; k++) coef_rom[k] = 16'h0200;
        run(16'h100, 4, 1'b0, 2);

        // Positive and negative saturation.
        for (int k = 0; k < 8; k++) begin
            samp_ram[10'h200 + k] = 16'h7F00;
            coef_rom[k] = 16'h0100;
        end
        run(16'h200, 8, 1'b0, 0);
        for (int k = 0; k < 8; k++) samp_ram[10'h200 + k] = 16'h8100;
        run(16'h200, 8, 1'b0, 1);

        // Zero length.
        run(16'h055, 0, 1'b0, 0);

        // Address wrap with backpressure and start held high.
        run(16'h3FE, 4, 1'b1, 10);
        run(16'h3FE, 4, 1'b0, 0);

        // Reset mid-run at tap 2, then a clean single-tap run.
        @(negedge clk);
        sample_base = 10'h020; len = 8'd16; start = 1'b1;
        while (!model_busy) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midrun_reset");
        rst = 1'b1;
        samp_ram[10'h300] = 16'hFE80; coef_rom[0] = 16'h0300;
        run(16'h300, 1, 1'b0, 0);

        // Random runs.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) coef_rom[i] = 16'($urandom_range(0, 16'hFFFF));
            for (int i = 0; i < 1024; i++) samp_ram[i] = 16'($urandom);
            run(int'($urandom_range(0, 1023)), int'($urandom_range(1, 32)), 1'b0,
                int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("addr_q_empty", addr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
